// File: rtl/store_merge_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_merge_unit_pkg
//  Description : Shared memory-access definitions for the store merge unit:
//                FSM state encodings, store kinds and lane-select width.
//  Revision    : 1.0 - initial release
// ============================================================================
package store_merge_unit_pkg;

    localparam int WORD_W = 32;
    localparam int LANE_SEL_W = 2;

    // FSM state encodings
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_READ  = 3'd1;
    localparam logic [2:0] c_MERGE = 3'd2;
    localparam logic [2:0] c_WRITE = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;
    localparam logic [2:0] c_ERR   = 3'd5;

    typedef enum logic [1:0] {
        KIND_SW = 2'd0,
        KIND_SB = 2'd1,
        KIND_SH = 2'd2
    } storeKind_t;

    // Store-byte wins when both selects are raised.
    function automatic storeKind_t decodeKind(input logic sb, input logic sh);
        if (sb)
            return KIND_SB;
        else if (sh)
            return KIND_SH;
        else
            return KIND_SW;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_merge_unit_lane_merge.sv
`default_nettype none
// ============================================================================
//  Module      : store_lane_merge
//  Description : Combinational read-modify-write merge. Replaces one byte
//                (sb) or one half-word (sh) lane of oldWord with the low bits
//                of storeData; all other lanes pass through untouched.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_lane_merge
    import store_merge_unit_pkg::*;
(
    input  logic [WORD_W-1:0]     oldWord,
    input  logic [WORD_W-1:0]     storeData,
    input  logic [LANE_SEL_W-1:0] addrLow,
    input  logic                  sb,
    input  logic                  sh,
    output logic [WORD_W-1:0]     newWord
);

    // Upper store bits are never merged; folded here to keep them visibly sunk.
    logic w_unused;
    assign w_unused = ^storeData[31:16];

    // Little-endian lane replacement; sb takes priority over sh.
    always_comb begin
        newWord = oldWord;
        if (sb) begin
            newWord[{addrLow, 3'b000} +: 8] = storeData[7:0];
        end else if (sh) begin
            if (addrLow[1])
                newWord[31:16] = storeData[15:0];
            else
                newWord[15:0]  = storeData[15:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_merge_unit.sv
`default_nettype none
// ============================================================================
//  Module      : store_merge_unit
//  Description : Sequences sub-word stores into a word-wide data memory.
//                sw writes directly; sb/sh read the word, merge the lane and
//                write it back. Misaligned requests are rejected.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_merge_unit
    import store_merge_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sbSignal,
    input  logic        shSignal,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    input  logic [31:0] memReadData,
    output logic [31:0] memAddr,
    output logic        memRead,
    output logic        memWrite,
    output logic [31:0] memWriteData,
    output logic        busy,
    output logic        done,
    output logic        misaligned
);

    logic [2:0]            r_state;
    logic [WORD_W-1:0]     r_wordAddr;
    logic [LANE_SEL_W-1:0] r_addrLow;
    logic [WORD_W-1:0]     r_storeData;
    storeKind_t            r_kind;
    logic [WORD_W-1:0]     r_writeData;

    storeKind_t            w_kind;
    logic [2:0]            w_idleNext;
    logic [WORD_W-1:0]     w_mergedWord;

    assign w_kind = decodeKind(sbSignal, shSignal);

    // Route a fresh request: sw goes straight to WRITE, sub-word stores read first.
    always_comb begin
        w_idleNext = c_IDLE;
        case (w_kind)
            KIND_SB: w_idleNext = c_READ;
            KIND_SH: w_idleNext = addr[0] ? c_ERR : c_READ;
            default: w_idleNext = (addr[1:0] != 2'b00) ? c_ERR : c_WRITE;
        endcase
    end

    store_lane_merge u_laneMerge (
        .oldWord   (memReadData),
        .storeData (r_storeData),
        .addrLow   (r_addrLow),
        .sb        (r_kind == KIND_SB),
        .sh        (r_kind == KIND_SH),
        .newWord   (w_mergedWord)
    );

    // Request latching, FSM sequencing and merged-word capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_wordAddr  <= '0;
            r_addrLow   <= '0;
            r_storeData <= '0;
            r_kind      <= KIND_SW;
            r_writeData <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_wordAddr  <= {addr[31:2], 2'b00};
                        r_addrLow   <= addr[1:0];
                        r_storeData <= storeData;
                        r_kind      <= w_kind;
                        // A word store needs no merge, so its data is final now.
                        r_writeData <= storeData;
                        r_state     <= w_idleNext;
                    end
                end
                c_READ:  r_state <= c_MERGE;
                c_MERGE: begin
                    r_writeData <= w_mergedWord;
                    r_state     <= c_WRITE;
                end
                c_WRITE: r_state <= c_DONE;
                c_DONE:  r_state <= c_IDLE;
                c_ERR:   r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Outputs decode directly from state so reset clears them in the same cycle.
    assign busy         = (r_state != c_IDLE);
    assign memRead      = (r_state == c_READ);
    assign memWrite     = (r_state == c_WRITE);
    assign done         = (r_state == c_DONE) || (r_state == c_ERR);
    assign misaligned   = (r_state == c_ERR);
    assign memAddr      = busy ? r_wordAddr  : '0;
    assign memWriteData = busy ? r_writeData : '0;

endmodule
`default_nettype wire

// File: tb/tb_store_merge_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_merge_unit
//  Description : Directed self-checking bench for store_merge_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_merge_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sbSignal;
    logic        shSignal;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic [31:0] memReadData;
    logic [31:0] memAddr;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memWriteData;
    logic        busy;
    logic        done;
    logic        misaligned;

    int checkCount = 0;
    int errorCount = 0;

    // Per-cycle observations, index = cycles after the start cycle
    logic        obsRead  [1:7];
    logic        obsWrite [1:7];
    logic        obsDone  [1:7];
    logic        obsMis   [1:7];
    logic        obsBusy  [1:7];
    logic [31:0] obsData  [1:7];
    logic [31:0] obsAddr  [1:7];

    store_merge_unit dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .sbSignal     (sbSignal),
        .shSignal     (shSignal),
        .addr         (addr),
        .storeData    (storeData),
        .memReadData  (memReadData),
        .memAddr      (memAddr),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memWriteData (memWriteData),
        .busy         (busy),
        .done         (done),
        .misaligned   (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and record outputs for cycles +1..+7 (sampled on negedges).
    task automatic runOp(input logic isSb, input logic isSh, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd, input int holdCycles);
        @(negedge clk);
        sbSignal    = isSb;
        shSignal    = isSh;
        addr        = a;
        storeData   = d;
        memReadData = rd;
        start       = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            obsRead[k]  = memRead;
            obsWrite[k] = memWrite;
            obsDone[k]  = done;
            obsMis[k]   = misaligned;
            obsBusy[k]  = busy;
            obsData[k]  = memWriteData;
            obsAddr[k]  = memAddr;
            if (k >= holdCycles) start = 1'b0;
        end
    endtask

    function automatic int countReads();
        int n = 0;
        for (int k = 1; k <= 7; k++) if (obsRead[k]) n++;
        return n;
    endfunction

    function automatic int countWrites();
        int n = 0;
        for (int k = 1; k <= 7; k++) if (obsWrite[k]) n++;
        return n;
    endfunction

    function automatic int countDones();
        int n = 0;
        for (int k = 1; k <= 7; k++) if (obsDone[k]) n++;
        return n;
    endfunction

    function automatic logic overlap();
        logic o = 1'b0;
        for (int k = 1; k <= 7; k++) if (obsRead[k] && obsWrite[k]) o = 1'b1;
        return o;
    endfunction

    initial begin
        int sawWrite;
        int sawDone;
        reset       = 1'b1;
        start       = 1'b0;
        sbSignal    = 1'b0;
        shSignal    = 1'b0;
        addr        = '0;
        storeData   = '0;
        memReadData = '0;
        repeat (2) @(negedge clk);

        // Reset state
        checkValue("rst_busy",  32'(busy), 32'd0);
        checkValue("rst_done",  32'(done), 32'd0);
        checkValue("rst_rd",    32'(memRead), 32'd0);
        checkValue("rst_wr",    32'(memWrite), 32'd0);
        checkValue("rst_addr",  memAddr, 32'h0);
        checkValue("rst_wdata", memWriteData, 32'h0);
        reset = 1'b0;

        // sw, aligned
        runOp(1'b0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h1234_5678, 1);
        checkValue("sw_wr1",    32'(obsWrite[1]), 32'd1);
        checkValue("sw_addr1",  obsAddr[1], 32'h0000_0010);
        checkValue("sw_data1",  obsData[1], 32'hDEAD_BEEF);
        checkValue("sw_done1",  32'(obsDone[1]), 32'd0);
        checkValue("sw_done2",  32'(obsDone[2]), 32'd1);
        checkValue("sw_reads",  32'(countReads()), 32'd0);
        checkValue("sw_writes", 32'(countWrites()), 32'd1);
        checkValue("sw_mis2",   32'(obsMis[2]), 32'd0);
        checkValue("sw_busy3",  32'(obsBusy[3]), 32'd0);
        checkValue("sw_idle_data3", obsData[3], 32'h0);

        // sb lane 2
        runOp(1'b1, 1'b0, 32'h0000_0022, 32'h0000_00AB, 32'h1122_3344, 1);
        checkValue("sb_rd1",    32'(obsRead[1]), 32'd1);
        checkValue("sb_addr1",  obsAddr[1], 32'h0000_0020);
        checkValue("sb_reads",  32'(countReads()), 32'd1);
        checkValue("sb_wr3",    32'(obsWrite[3]), 32'd1);
        checkValue("sb_writes", 32'(countWrites()), 32'd1);
        checkValue("sb_addr3",  obsAddr[3], 32'h0000_0020);
        checkValue("sb_data3",  obsData[3], 32'h11AB_3344);
        checkValue("sb_done3",  32'(obsDone[3]), 32'd0);
        checkValue("sb_done4",  32'(obsDone[4]), 32'd1);
        checkValue("sb_overlap", 32'(overlap()), 32'd0);

        // sh upper and lower halves
        runOp(1'b0, 1'b1, 32'h0000_0006, 32'h0000_CAFE, 32'hFFFF_FFFF, 1);
        checkValue("sh_hi_data3", obsData[3], 32'hCAFE_FFFF);
        checkValue("sh_hi_done4", 32'(obsDone[4]), 32'd1);
        runOp(1'b0, 1'b1, 32'h0000_0004, 32'h0000_CAFE, 32'hFFFF_FFFF, 1);
        checkValue("sh_lo_data3", obsData[3], 32'hFFFF_CAFE);
        checkValue("sh_lo_addr3", obsAddr[3], 32'h0000_0004);

        // sh misaligned
        runOp(1'b0, 1'b1, 32'h0000_0003, 32'h0000_CAFE, 32'hFFFF_FFFF, 1);
        checkValue("shmis_done1", 32'(obsDone[1]), 32'd1);
        checkValue("shmis_mis1",  32'(obsMis[1]), 32'd1);
        checkValue("shmis_rw",    32'(countReads() + countWrites()), 32'd0);
        checkValue("shmis_busy2", 32'(obsBusy[2]), 32'd0);

        // sw misaligned
        runOp(1'b0, 1'b0, 32'h0000_0012, 32'h0BAD_F00D, 32'h0, 1);
        checkValue("swmis_mis1", 32'(obsMis[1]), 32'd1);
        checkValue("swmis_rw",   32'(countReads() + countWrites()), 32'd0);

        // sb and sh both set: sb wins
        runOp(1'b1, 1'b1, 32'h0000_0001, 32'h0000_0055, 32'h0000_0000, 1);
        checkValue("both_data3", obsData[3], 32'h0000_5500);
        checkValue("both_done4", 32'(obsDone[4]), 32'd1);

        // start held through the done cycle: only one operation happens
        runOp(1'b1, 1'b0, 32'h0000_0003, 32'h0000_0077, 32'h0000_0000, 4);
        checkValue("hold_data3",  obsData[3], 32'h7700_0000);
        checkValue("hold_writes", 32'(countWrites()), 32'd1);
        checkValue("hold_dones",  32'(countDones()), 32'd1);
        checkValue("hold_busy5",  32'(obsBusy[5]), 32'd0);

        // reset while in MERGE
        @(negedge clk);
        sbSignal    = 1'b1;
        shSignal    = 1'b0;
        addr        = 32'h0000_0020;
        storeData   = 32'h0000_00AA;
        memReadData = 32'h1234_5678;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkValue("abort_busy_pre", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        checkValue("abort_busy", 32'(busy), 32'd0);
        checkValue("abort_addr", memAddr, 32'h0);
        checkValue("abort_outs", {26'd0, memRead, memWrite, done, misaligned, 1'b0, 1'b0}, 32'h0);
        #1 reset = 1'b0;
        sawWrite = 0;
        sawDone  = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (memWrite) sawWrite++;
            if (done) sawDone++;
        end
        checkValue("abort_nowrite", 32'(sawWrite), 32'd0);
        checkValue("abort_nodone",  32'(sawDone), 32'd0);

        // fresh sw after the abort
        runOp(1'b0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1);
        checkValue("post_wr1",   32'(obsWrite[1]), 32'd1);
        checkValue("post_data1", obsData[1], 32'hDEAD_BEEF);
        checkValue("post_done2", 32'(obsDone[2]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    // Global watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/store_merge_unit.md
STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: request strobe, sampled only in IDLE.
REQ-004 The block SHALL have the ports sbSignal and shSignal, inputs, 1 bit each: store-byte and store-half select; both low means store-word.
REQ-005 The block SHALL have the port addr, input, 32 bits: byte address of the store.
REQ-006 The block SHALL have the port storeData, input, 32 bits: register value to store; sb uses bits 7:0, sh uses bits 15:0.
REQ-007 The block SHALL have the port memReadData, input, 32 bits: data-memory read word, valid the cycle after memRead is high.
REQ-008 The block SHALL have the port memAddr, output, 32 bits: word address {addr[31:2],2'b00}.
REQ-009 The block SHALL have the ports memRead and memWrite, outputs, 1 bit each: data-memory strobes.
REQ-010 The block SHALL have the port memWriteData, output, 32 bits: merged word to write.
REQ-011 The block SHALL have the ports busy, done and misaligned, outputs, 1 bit each: busy when not IDLE; done is a one-cycle completion pulse; misaligned is high with done on a rejected request.

Function
REQ-012 The FSM SHALL have the states IDLE, READ, MERGE, WRITE, DONE and ERR.
REQ-013 In IDLE with start=1, the block SHALL latch addr, storeData and the store kind; sbSignal=1 SHALL select sb regardless of shSignal.
REQ-014 IDLE SHALL transition to WRITE for sw, to READ for sb, to READ for sh with addr[0]=0, and to ERR for sh with addr[0]=1.
REQ-015 sw with addr[1:0]!=0 SHALL transition to ERR.
REQ-016 READ SHALL assert memRead for exactly one cycle, then go to MERGE.
REQ-017 MERGE SHALL register memReadData with the selected lane replaced, then go to WRITE.
REQ-018 sb lane SHALL be addr[1:0]: lane 0 is bits 7:0 and lane 3 is bits 31:24 (little-endian); the other bytes SHALL be preserved.
REQ-019 sh lane SHALL be addr[1]: 0 selects bits 15:0 and 1 selects bits 31:16; the other half SHALL be preserved.
REQ-020 sw SHALL write storeData unmodified without reading memory.
REQ-021 WRITE SHALL assert memWrite for exactly one cycle with memWriteData stable, then go to DONE.
REQ-022 DONE SHALL pulse done for one cycle and then return to IDLE.
REQ-023 ERR SHALL pulse done and misaligned for one cycle, perform no memRead or memWrite, and return to IDLE.
REQ-024 Latency from the start cycle SHALL be: sw done at cycle +2; sb/sh done at cycle +4; error done at cycle +1.
REQ-025 start SHALL be ignored while busy; a start in the same cycle done is high SHALL be ignored (busy is still 1).
REQ-026 memAddr SHALL hold the latched word address from READ through WRITE; in IDLE, memAddr and memWriteData SHALL be 0.
REQ-027 memRead and memWrite SHALL never be high in the same cycle.

Reset
REQ-028 reset=1 SHALL force IDLE immediately (asynchronously) and clear every output and latched register to 0.
REQ-029 reset asserted mid-operation SHALL abort the operation: no further memWrite and no done pulse.

Structure
REQ-030 The state encodings and a lane-select width constant SHALL reside in a shared package with the other memory-access definitions.
REQ-031 The lane merge SHALL be a combinational sub-module store_lane_merge(oldWord, storeData, addrLow, sb, sh) -> newWord; the FSM and registers SHALL reside in the top module.

Verification
REQ-032 The bench SHALL check: sw at addr 0x00000010, storeData 0xDEADBEEF -> memWrite at +1 with memAddr 0x10 and data 0xDEADBEEF, done at +2, memRead never asserted.
REQ-033 The bench SHALL check: sb at addr 0x00000022, storeData 0x000000AB, memReadData 0x11223344 -> memRead at +1, memWrite at +3 with data 0x11AB3344, done at +4.
REQ-034 The bench SHALL check: sh at addr 0x00000006, storeData 0x0000CAFE, memReadData 0xFFFFFFFF -> write data 0xCAFEFFFF; sh at addr 0x00000004 -> write data 0xFFFFCAFE.
REQ-035 The bench SHALL check: sh at addr 0x00000003 -> done and misaligned at +1, with memRead and memWrite low throughout.
REQ-036 The bench SHALL check: sbSignal=shSignal=1 at addr 0x00000001, storeData 0x55, memReadData 0 -> treated as sb, write data 0x00005500.
REQ-037 The bench SHALL check: reset pulsed while in MERGE -> all outputs 0 in the same cycle, no memWrite or done follows, and a fresh sw then completes normally.
